// File: rtl/btclk_multilink.sv
// btclk_multilink: one shared native Bluetooth clock with per-link offset clocks,
// slot-end strobes, correlator uncertainty windows and the PLL frequency-set strobe.
module btclk_multilink #(
  parameter int NCH  = 2,
  parameter int CLKW = 28,
  parameter int WINW = 9
) (
  input  logic                  clk_6M,
  input  logic                  rst,
  input  logic [CLKW-1:0]       native_offset,
  input  logic [9:0]            pllsetuptime,
  input  logic [NCH-1:0]        ch_en,
  input  logic [NCH-1:0]        ch_role,
  input  logic [NCH-1:0]        ch_off_wr,
  input  logic [CLKW-3:0]       ch_off_wdata,
  input  logic [NCH*WINW-1:0]   ch_winsize,
  output logic                  p_05us,
  output logic                  p_1us,
  output logic [10:0]           slot_hu,
  output logic                  half_tslot_p,
  output logic                  tslot_p,
  output logic [CLKW-1:0]       CLKN,
  output logic [NCH*CLKW-1:0]   ch_clk,
  output logic [NCH-1:0]        ch_tx_endp,
  output logic [NCH-1:0]        ch_rx_endp,
  output logic [NCH-1:0]        ch_win,
  output logic                  fkset_p
);

  logic [2:0]               cnt6_q, cnt6_d;
  logic [10:0]              slotHu_q, slotHu_d;
  logic [CLKW-1:0]          clkr_q, clkr_d;
  logic [NCH-1:0][CLKW-3:0] off_q, off_d, pend_q, pend_d;
  logic [NCH-1:0]           pendFlag_q, pendFlag_d, win_q, win_d;
  logic [NCH-1:0][CLKW-1:0] chClk;
  logic [NCH-1:0]           txSlot;
  logic [NCH-1:0][31:0]     winSize, openAt, closeAt;
  logic [31:0]              huExt, pll, fkFirst, fkSecond;

  assign huExt   = 32'(slotHu_q);
  assign slot_hu = slotHu_q;
  assign CLKN    = clkr_q + native_offset;
  assign ch_clk  = chClk;
  assign ch_win  = win_q;

  // Half-microsecond ticks, slot position and the CLKR half-slot counter
  always_comb begin
    p_05us       = (cnt6_q == 3'd2) || (cnt6_q == 3'd5);
    p_1us        = (cnt6_q == 3'd5);
    tslot_p      = p_05us && (slotHu_q == 11'd1249);
    half_tslot_p = p_05us && ((slotHu_q == 11'd624) || (slotHu_q == 11'd1249));
    cnt6_d       = (cnt6_q == 3'd5) ? 3'd0 : cnt6_q + 3'd1;
    slotHu_d     = slotHu_q;
    if (p_05us) begin
      slotHu_d = (slotHu_q == 11'd1249) ? 11'd0 : slotHu_q + 11'd1;
    end
    clkr_d = half_tslot_p ? clkr_q + CLKW'(1) : clkr_q;
  end

  // Per-link clock, slot-end strobes, window next state and slot-aligned offset update
  always_comb begin
    off_d      = off_q;
    pend_d     = pend_q;
    pendFlag_d = pendFlag_q;
    win_d      = win_q;
    chClk      = '0;
    txSlot     = '0;
    winSize    = '0;
    openAt     = '0;
    closeAt    = '0;
    ch_tx_endp = '0;
    ch_rx_endp = '0;
    for (int i = 0; i < NCH; i++) begin
      chClk[i]      = CLKN + {off_q[i], 2'b00};
      txSlot[i]     = chClk[i][1] ^ ch_role[i];
      ch_tx_endp[i] = ch_en[i] & tslot_p & txSlot[i];
      ch_rx_endp[i] = ch_en[i] & tslot_p & ~txSlot[i];
      winSize[i]    = 32'(ch_winsize[i*WINW +: WINW]);
      openAt[i]     = 32'd1250 - (winSize[i] << 1);
      closeAt[i]    = 32'd136 + (winSize[i] << 1);
      if (!ch_en[i]) begin
        win_d[i] = 1'b0;
      end else if (winSize[i] > 32'd312) begin
        win_d[i] = 1'b1;
      end else if (p_05us && (huExt == openAt[i]) && txSlot[i]) begin
        win_d[i] = 1'b1;
      end else if (p_05us && (huExt == closeAt[i]) && !txSlot[i]) begin
        win_d[i] = 1'b0;
      end
      if (tslot_p && pendFlag_q[i]) begin
        off_d[i]      = pend_q[i];
        pendFlag_d[i] = 1'b0;
      end
      if (ch_off_wr[i]) begin
        pend_d[i]     = ch_off_wdata;
        pendFlag_d[i] = 1'b1;
      end
    end
  end

  // Frequency-set strobe fires PLL setup time ahead of each half-slot boundary
  always_comb begin
    pll      = 32'(pllsetuptime);
    fkFirst  = 32'd2 * (32'd312 - pll);
    fkSecond = 32'd2 * (32'd624 - pll);
    fkset_p  = p_05us && (ch_en != '0) && (pll <= 32'd312) &&
               ((huExt == fkFirst) || (huExt == fkSecond));
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_6M) begin
    if (rst) begin
      cnt6_q     <= '0;
      slotHu_q   <= '0;
      clkr_q     <= '0;
      off_q      <= '0;
      pend_q     <= '0;
      pendFlag_q <= '0;
      win_q      <= '0;
    end else begin
      cnt6_q     <= cnt6_d;
      slotHu_q   <= slotHu_d;
      clkr_q     <= clkr_d;
      off_q      <= off_d;
      pend_q     <= pend_d;
      pendFlag_q <= pendFlag_d;
      win_q      <= win_d;
    end
  end

endmodule

// File: tb/tb_btclk_multilink.sv
// tb_btclk_multilink: cycle-accurate check of btclk_multilink against a timing model
// derived from the elapsed cycle count, with directed anchors and randomized traffic.
`timescale 1ns/1ps
module tb_btclk_multilink;
  localparam int NCH  = 2;
  localparam int CLKW = 28;
  localparam int WINW = 9;
  localparam int OW   = CLKW - 2;

  logic                clk_6M = 1'b0;
  logic                rst = 1'b1;
  logic [CLKW-1:0]     native_offset = '0;
  logic [9:0]          pllsetuptime = '0;
  logic [NCH-1:0]      ch_en = '0, ch_role = '0, ch_off_wr = '0;
  logic [OW-1:0]       ch_off_wdata = '0;
  logic [NCH*WINW-1:0] ch_winsize = '0;
  logic                p_05us, p_1us, half_tslot_p, tslot_p, fkset_p;
  logic [10:0]         slot_hu;
  logic [CLKW-1:0]     CLKN;
  logic [NCH*CLKW-1:0] ch_clk;
  logic [NCH-1:0]      ch_tx_endp, ch_rx_endp, ch_win;

  btclk_multilink #(.NCH(NCH), .CLKW(CLKW), .WINW(WINW)) dut (
    .clk_6M(clk_6M), .rst(rst), .native_offset(native_offset), .pllsetuptime(pllsetuptime),
    .ch_en(ch_en), .ch_role(ch_role), .ch_off_wr(ch_off_wr), .ch_off_wdata(ch_off_wdata),
    .ch_winsize(ch_winsize), .p_05us(p_05us), .p_1us(p_1us), .slot_hu(slot_hu),
    .half_tslot_p(half_tslot_p), .tslot_p(tslot_p), .CLKN(CLKN), .ch_clk(ch_clk),
    .ch_tx_endp(ch_tx_endp), .ch_rx_endp(ch_rx_endp), .ch_win(ch_win), .fkset_p(fkset_p)
  );

  always #5 clk_6M = ~clk_6M;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: every timing quantity follows from cycles elapsed since reset
  int                       mt;
  bit                       modelOn = 1'b0;
  logic [NCH-1:0][OW-1:0]   mOff, mPend;
  logic [NCH-1:0]           mFlag, mWin, eTx, eRx;
  logic [NCH-1:0][CLKW-1:0] eClk;
  logic [CLKW-1:0]          eClkr, eClkn;
  int                       hu, w, pInt;
  bit                       p05, p1, half, tslot, eFk, isTx;

  always @(negedge clk_6M) begin
    if (rst) begin
      mt = 0; mOff = '0; mPend = '0; mFlag = '0; mWin = '0; modelOn = 1'b1;
    end else if (modelOn) begin
      hu    = (mt / 3) % 1250;
      p05   = (mt % 6 == 2) || (mt % 6 == 5);
      p1    = (mt % 6 == 5);
      half  = p05 && (hu == 624 || hu == 1249);
      tslot = p05 && (hu == 1249);
      eClkr = CLKW'(mt / 1875);
      eClkn = eClkr + native_offset;
      pInt  = int'(pllsetuptime);
      eFk   = p05 && (ch_en != '0) && (pInt <= 312) &&
              (hu == 2 * (312 - pInt) || hu == 2 * (624 - pInt));
      for (int i = 0; i < NCH; i++) begin
        eClk[i] = eClkn + {mOff[i], 2'b00};
        isTx    = (eClk[i][1] != ch_role[i]);
        eTx[i]  = ch_en[i] && tslot && isTx;
        eRx[i]  = ch_en[i] && tslot && !isTx;
      end
      checkOutput("p_05us", 64'(p_05us), 64'(p05));
      checkOutput("p_1us", 64'(p_1us), 64'(p1));
      checkOutput("slot_hu", 64'(slot_hu), 64'(hu));
      checkOutput("half_tslot_p", 64'(half_tslot_p), 64'(half));
      checkOutput("tslot_p", 64'(tslot_p), 64'(tslot));
      checkOutput("CLKN", 64'(CLKN), 64'(eClkn));
      checkOutput("ch_clk", 64'(ch_clk), 64'(eClk));
      checkOutput("ch_tx_endp", 64'(ch_tx_endp), 64'(eTx));
      checkOutput("ch_rx_endp", 64'(ch_rx_endp), 64'(eRx));
      checkOutput("ch_win", 64'(ch_win), 64'(mWin));
      checkOutput("fkset_p", 64'(fkset_p), 64'(eFk));
      for (int i = 0; i < NCH; i++) begin
        w    = int'(ch_winsize[i*WINW +: WINW]);
        isTx = (eClk[i][1] != ch_role[i]);
        if (!ch_en[i]) mWin[i] = 1'b0;
        else if (w > 312) mWin[i] = 1'b1;
        else if (p05 && hu == 1250 - 2 * w && isTx) mWin[i] = 1'b1;
        else if (p05 && hu == 136 + 2 * w && !isTx) mWin[i] = 1'b0;
        if (tslot && mFlag[i]) begin
          mOff[i]  = mPend[i];
          mFlag[i] = 1'b0;
        end
        if (ch_off_wr[i]) begin
          mPend[i] = ch_off_wdata;
          mFlag[i] = 1'b1;
        end
      end
      mt++;
    end
  end

  task automatic gotoCycle(input int n);
    while (cyc < n) begin
      @(posedge clk_6M); #1;
      cyc++;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    ch_off_wr = '0;
    @(posedge clk_6M); #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] en, input logic [NCH-1:0] role,
                               input logic [NCH*WINW-1:0] ws, input logic [9:0] pll,
                               input logic [CLKW-1:0] noff);
    ch_en = en; ch_role = role; ch_winsize = ws; pllsetuptime = pll; native_offset = noff;
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NCH*WINW-1:0] ws;
    @(posedge clk_6M); #1;
    // Ch0 master W=10, ch1 slave W=400, both enabled, PLL setup 12 us
    applyStimulus(2'b11, 2'b01, {9'd400, 9'd10}, 10'd12, '0);
    doReset();
    #2;
    checkOutput("reset p_05us", 64'(p_05us), 64'd0);
    checkOutput("reset tslot_p", 64'(tslot_p), 64'd0);
    checkOutput("reset CLKN", 64'(CLKN), 64'd0);
    checkOutput("reset ch_win", 64'(ch_win), 64'd0);
    gotoCycle(1); #2;
    checkOutput("W400 window on", 64'(ch_win), 64'b10);
    gotoCycle(2); #2;
    checkOutput("first p_05us", 64'(p_05us), 64'd1);
    gotoCycle(5); #2;
    checkOutput("first p_1us", 64'(p_1us), 64'd1);
    gotoCycle(100);
    ch_off_wr = 2'b01; ch_off_wdata = OW'(1);
    gotoCycle(101);
    ch_off_wr = '0;
    #2;
    checkOutput("ch_clk0 before apply", 64'(ch_clk[CLKW-1:0]), 64'd0);
    gotoCycle(1802); #2;
    checkOutput("fkset at 600", 64'(fkset_p), 64'd1);
    gotoCycle(1874); #2;
    checkOutput("first half_tslot_p", 64'(half_tslot_p), 64'd1);
    gotoCycle(1875); #2;
    checkOutput("CLKN after half slot", 64'(CLKN), 64'd1);
    gotoCycle(3692); #2;
    checkOutput("win0 before open", 64'(ch_win[0]), 64'd0);
    gotoCycle(3693); #2;
    checkOutput("win0 open", 64'(ch_win[0]), 64'd1);
    gotoCycle(3749); #2;
    checkOutput("first tslot_p", 64'(tslot_p), 64'd1);
    checkOutput("ch_clk0 at slot end", 64'(ch_clk[CLKW-1:0]), 64'd1);
    checkOutput("tx_endp slot0", 64'(ch_tx_endp), 64'b01);
    checkOutput("rx_endp slot0", 64'(ch_rx_endp), 64'b10);
    ch_off_wr = 2'b01; ch_off_wdata = OW'(2);
    gotoCycle(3750);
    ch_off_wr = '0;
    #2;
    checkOutput("CLKN after slot", 64'(CLKN), 64'd2);
    checkOutput("ch_clk0 offset 1", 64'(ch_clk[CLKW-1:0]), 64'd6);
    gotoCycle(4220); #2;
    checkOutput("win0 before close", 64'(ch_win[0]), 64'd1);
    gotoCycle(4221); #2;
    checkOutput("win0 closed", 64'(ch_win[0]), 64'd0);
    gotoCycle(7499); #2;
    checkOutput("ch_clk0 slot1 end", 64'(ch_clk[CLKW-1:0]), 64'd7);
    checkOutput("tx_endp slot1", 64'(ch_tx_endp), 64'b10);
    checkOutput("rx_endp slot1", 64'(ch_rx_endp), 64'b01);
    gotoCycle(7500); #2;
    checkOutput("ch_clk0 offset 2", 64'(ch_clk[CLKW-1:0]), 64'd12);
    gotoCycle(7600);
    ch_en = '0;
    gotoCycle(7601); #2;
    checkOutput("window forced off", 64'(ch_win), 64'd0);

    // Wrap of CLKN through the native offset; reset must discard offsets
    applyStimulus(2'b01, 2'b01, {9'd0, 9'd10}, 10'd313, CLKW'(28'h0FFFFFFF));
    doReset();
    #2;
    checkOutput("wrap CLKN t0", 64'(CLKN), 64'h0FFFFFFF);
    checkOutput("wrap ch_clk0 t0", 64'(ch_clk[CLKW-1:0]), 64'h0FFFFFFF);
    gotoCycle(1875); #2;
    checkOutput("wrap CLKN half", 64'(CLKN), 64'd0);
    gotoCycle(3750); #2;
    checkOutput("wrap CLKN slot", 64'(CLKN), 64'd1);
    checkOutput("wrap ch_clk0 slot", 64'(ch_clk[CLKW-1:0]), 64'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 20000; n++) begin
      if (n == 10000) doReset();
      if (n % 700 == 0) begin
        for (int i = 0; i < NCH; i++)
          ws[i*WINW +: WINW] = ($urandom_range(0, 9) == 0) ? WINW'($urandom_range(313, 511))
                                                           : WINW'($urandom_range(0, 40));
        applyStimulus(NCH'($urandom), NCH'($urandom), ws,
                      ($urandom_range(0, 3) == 0) ? 10'($urandom_range(300, 1023))
                                                  : 10'($urandom_range(0, 312)),
                      CLKW'($urandom));
      end
      if ($urandom_range(0, 149) == 0) begin
        ch_off_wr = NCH'($urandom);
        ch_off_wdata = OW'($urandom);
      end else begin
        ch_off_wr = '0;
      end
      @(posedge clk_6M); #1;
      cyc++;
    end
    ch_off_wr = '0;
    @(negedge clk_6M);
    @(negedge clk_6M);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btclk_multilink.md
Name: btclk_multilink

Overview:
- Parametrised Bluetooth clock generator for NCH simultaneous links sharing one native clock.
- Derives 0.5 µs and 1 µs ticks, the slot position counter and native CLKR/CLKN from clk_6M.
- Each channel has a role, a slot-aligned offset that is updated only on slot boundaries, TX/RX slot-end strobes and a correlator uncertainty window.
- Sits between the link controller register bank and the per-link packet/hop engines.

Parameters:
NCH, 2, number of link channels (1..8)
CLKW, 28, Bluetooth clock width
WINW, 9, uncertainty window size width (µs)

Ports:
clk_6M  in  1  6 MHz system clock
rst  in  1  synchronous active-high reset
native_offset  in  CLKW  added to CLKR to form CLKN
pllsetuptime  in  10  PLL setup time in µs for fkset_p
ch_en  in  NCH  channel enable
ch_role  in  NCH  1=master, 0=slave per channel
ch_off_wr  in  NCH  offset write strobe per channel
ch_off_wdata  in  CLKW-2  offset value, units of 4 ticks
ch_winsize  in  NCH*WINW  window size per channel, µs
p_05us  out  1  0.5 µs tick
p_1us  out  1  1 µs tick
slot_hu  out  11  half-µs position in slot, 0..1249
half_tslot_p  out  1  CLKR increment strobe
tslot_p  out  1  slot end strobe
CLKN  out  CLKW  native clock
ch_clk  out  NCH*CLKW  per-channel clock
ch_tx_endp  out  NCH  TX slot end strobe
ch_rx_endp  out  NCH  RX slot end strobe
ch_win  out  NCH  uncertainty window, registered
fkset_p  out  1  frequency-set strobe

Behaviour:
- Synchronous active-high reset on clk_6M. All registers clear: cnt6, slot_hu, CLKR, ch offsets, pending flags and ch_win. All strobes read 0 on the first cycle after reset.
- cnt6 counts 0..5 and wraps.
  - p_05us = (cnt6==2 or cnt6==5).
  - p_1us = (cnt6==5).
  - All three are combinational from the registers.
- slot_hu advances on p_05us and wraps 1249->0.
  - half_tslot_p = p_05us & (slot_hu==624 or slot_hu==1249).
  - tslot_p = p_05us & slot_hu==1249.
  - Timing: half slot = 1875 cycles, slot = 3750 cycles.
- CLKR increments by 1 on half_tslot_p, modulo 2^CLKW. Invariant: CLKR[0] == (slot_hu>=625).
- CLKN = CLKR + native_offset, modulo 2^CLKW, combinational.
- Per-channel offset update:
  - ch_off_wr[i] loads pend_i and sets pend_flag_i.
  - On a later tslot_p with pend_flag_i set: off_i <= pend_i and pend_flag_i clears. The new offset is visible the cycle after that tslot_p.
  - A write in the same cycle as tslot_p applies at the following slot end.
  - A second write before the apply overwrites pend_i; the last write wins.
- ch_clk_i = CLKN + {off_i, 2'b00}, so bits [1:0] always equal CLKN[1:0].
- Slot-end strobes, all ANDed with ch_en[i]:
  - Master: tx_endp = tslot_p & !ch_clk_i[1]; rx_endp = tslot_p & ch_clk_i[1].
  - Slave: tx_endp = tslot_p & ch_clk_i[1]; rx_endp = tslot_p & !ch_clk_i[1].
  - The strobes use the pre-increment clock.
- Uncertainty window ch_win[i]. W = ch_winsize_i. "TXslot" means ch_clk_i[1]==ch_role[i]^1, i.e. master bit1=0, slave bit1=1. Priority, highest first:
  1. ch_en[i]==0 -> 0.
  2. W>312 -> 1.
  3. p_05us & slot_hu==1250-2W & TXslot -> 1.
  4. p_05us & slot_hu==136+2W & !TXslot -> 0.
  5. Otherwise hold.
  - W==0 never opens the window. The 11-bit compare holds for W≤312.
- fkset_p = p_05us & ch_en!=0 & (slot_hu==2*(312-P) or slot_hu==2*(624-P)), with P = pllsetuptime.
  - P>312 suppresses both terms.
  - P==0 fires at slot_hu 624 and 1248.
- Reset mid-operation discards all offsets and pending writes; counting restarts at cnt6=0.

Test Plan:
- Reset release, no writes:
  - p_05us at cycles 2, 5, 8.
  - p_1us at cycle 5, then every 6 cycles.
  - First half_tslot_p at cycle 1874, CLKN becomes 1.
  - First tslot_p at cycle 3749, CLKN becomes 2.
- native_offset=0x0FFFFFFF, one slot elapsed -> CLKN wraps to 0x0000001 after 2 ticks; no X, no carry out.
- Ch0 ch_off_wr with 0x1 at cycle 100:
  - ch_clk0 unchanged until after the tslot_p at cycle 3749.
  - From then ch_clk0 = CLKN+4.
  - A write on exactly cycle 3749 applies only at the next tslot_p (cycle 7499).
- Ch0 master, ch1 slave, both enabled, offset 0 -> at tslot_p with CLKN[1]=0: ch_tx_endp=01, ch_rx_endp=10; roles swap on the next slot.
- Ch0 master, W=10:
  - Window rises the cycle after slot_hu==1230 in a TX slot.
  - Falls the cycle after slot_hu==156 in the following RX slot.
  - W=400 -> constant 1.
  - ch_en=0 -> forced 0 within one cycle.
- pllsetuptime=12, one channel enabled -> fkset_p at slot_hu 600 and 1224 every slot. pllsetuptime=313 or ch_en=0 -> never.
